// File: rtl/puf_resp_uart_tx_pkg.sv
// Shared definitions for the PUF UART path: FSM encodings, line idle level and
// default baud divisor, common to the response transmitter and the challenge receiver.
package puf_resp_uart_tx_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;

  localparam int   DEFAULT_CLKS_PER_BIT = 868;
  localparam logic UART_IDLE            = 1'b1;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/puf_resp_uart_tx_baud_tick.sv
// Baud-rate divider: counts 0..CLKS_PER_BIT-1 while run is high and flags the
// terminal count; held at zero while idle so bit timing aligns to the frame start.
module uart_baud_tick
  import puf_resp_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic tick
);

  localparam int               CNT_W    = cnt_width(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    if (run) begin
      cnt_d = (cnt_q == TERMINAL) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = run && (cnt_q == TERMINAL);

endmodule

// File: rtl/puf_resp_uart_tx.sv
// Sends one latched PUF response word as NBYTES 8N1 UART bytes, MS byte first,
// with optional idle-high gap bits between bytes and a done pulse after the last stop bit.
module puf_resp_uart_tx
  import puf_resp_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int NBYTES       = 16,
  parameter int GAP_BITS     = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [8*NBYTES-1:0] data,
  output logic                tx_out,
  output logic                busy,
  output logic                done
);

  localparam int                W         = 8 * NBYTES;
  localparam int                BYTE_W    = cnt_width(NBYTES);
  localparam int                GAP_W     = cnt_width(GAP_BITS);
  localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(NBYTES - 1);
  localparam logic [GAP_W-1:0]  LAST_GAP  = GAP_W'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);
  localparam bit                HAS_GAP   = (GAP_BITS > 0);

  logic [2:0]        state_q, state_d;
  logic [W-1:0]      shift_q, shift_d;
  logic [BYTE_W-1:0] byte_idx_q, byte_idx_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic              tx_q, tx_d;
  logic              armed_q;
  logic              run, tick, last_byte;
  logic [7:0]        cur_byte;

  assign run       = (state_q != ST_IDLE);
  assign cur_byte  = shift_q[W-1 -: 8];
  assign last_byte = (byte_idx_q == LAST_BYTE);

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk (clk),
    .rst (rst),
    .run (run),
    .tick(tick)
  );

  // tx_d carries the line level of the state being entered, so the pin is a plain flop.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    byte_idx_d = byte_idx_q;
    bit_idx_d  = bit_idx_q;
    gap_cnt_d  = gap_cnt_q;
    tx_d       = tx_q;
    case (state_q)
      ST_IDLE: begin
        tx_d = UART_IDLE;
        if (start && armed_q) begin
          shift_d    = data;
          byte_idx_d = '0;
          bit_idx_d  = '0;
          gap_cnt_d  = '0;
          state_d    = ST_START;
          tx_d       = 1'b0;
        end
      end
      ST_START: begin
        if (tick) begin
          state_d   = ST_DATA;
          bit_idx_d = '0;
          tx_d      = cur_byte[0];
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (bit_idx_q == 3'd7) begin
            state_d = ST_STOP;
            tx_d    = UART_IDLE;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = cur_byte[bit_idx_q + 3'd1];
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (last_byte) begin
            state_d = ST_IDLE;
          end else begin
            byte_idx_d = byte_idx_q + 1'b1;
            shift_d    = {shift_q[W-9:0], 8'h00};
            if (HAS_GAP) begin
              state_d   = ST_GAP;
              gap_cnt_d = '0;
            end else begin
              state_d = ST_START;
              tx_d    = 1'b0;
            end
          end
        end
      end
      ST_GAP: begin
        if (tick) begin
          if (gap_cnt_q == LAST_GAP) begin
            state_d = ST_START;
            tx_d    = 1'b0;
          end else begin
            gap_cnt_d = gap_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = UART_IDLE;
      end
    endcase
  end

  // armed_q blocks an accept on the first edge after reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      byte_idx_q <= '0;
      bit_idx_q  <= '0;
      gap_cnt_q  <= '0;
      tx_q       <= UART_IDLE;
      armed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      byte_idx_q <= byte_idx_d;
      bit_idx_q  <= bit_idx_d;
      gap_cnt_q  <= gap_cnt_d;
      tx_q       <= tx_d;
      armed_q    <= 1'b1;
    end
  end

  assign tx_out = tx_q;
  assign busy   = run;
  assign done   = (state_q == ST_STOP) && tick && last_byte;

endmodule

// File: tb/tb_puf_resp_uart_tx.sv
// Directed bench for puf_resp_uart_tx: a cycle-exact line model checks tx_out, busy and
// done every cycle; a second instance runs with two gap bits between bytes.
module tb_puf_resp_uart_tx;

  localparam int CPB = 4;
  localparam int NB  = 16;

  logic         clk;
  logic         rst;
  logic         start;
  logic         startG;
  logic [127:0] dataIn;
  logic         tx, busy, done;
  logic         txG, busyG, doneG;

  int checkCount = 0;
  int passCount  = 0;
  logic cap [0:4095];

  puf_resp_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .NBYTES      (NB),
    .GAP_BITS    (0)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .data  (dataIn),
    .tx_out(tx),
    .busy  (busy),
    .done  (done)
  );

  puf_resp_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .NBYTES      (NB),
    .GAP_BITS    (2)
  ) dut_gap (
    .clk   (clk),
    .rst   (rst),
    .start (startG),
    .data  (dataIn),
    .tx_out(txG),
    .busy  (busyG),
    .done  (doneG)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got === exp) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; the next negedge is the first start-bit cycle of the frame.
  task automatic applyStimulus(input bit useGap, input logic [127:0] d);
    dataIn = d;
    if (useGap) startG = 1'b1;
    else        start  = 1'b1;
    @(negedge clk);
    if (useGap) startG = 1'b0;
    else        start  = 1'b0;
  endtask

  // There is no gap after the final byte: done follows its stop bit directly.
  task automatic observeFrames(input string tag, input bit useGap, input logic [127:0] d,
                               input int nFrames, input bit holdStart,
                               input int injectAt, input logic [127:0] injData);
    int g, per, frameLen, total, f, p, b, w, bp;
    int lineErr, busyErr, doneErr, doneCnt, firstDone;
    logic expTx, expBusy, expDone, obsTx, obsBusy, obsDone;
    logic [7:0] curByte, dec;
    g         = useGap ? 2 : 0;
    per       = (10 + g) * CPB;
    frameLen  = NB * per - g * CPB;
    total     = nFrames * (frameLen + 1) + 2;
    lineErr   = 0;
    busyErr   = 0;
    doneErr   = 0;
    doneCnt   = 0;
    firstDone = -1;
    for (int k = 0; k < total; k++) begin
      f = k / (frameLen + 1);
      p = k % (frameLen + 1);
      if (f < nFrames && p < frameLen) begin
        b       = p / per;
        w       = p % per;
        bp      = w / CPB;
        curByte = d[127 - 8*b -: 8];
        if (bp == 0)      expTx = 1'b0;
        else if (bp <= 8) expTx = curByte[bp-1];
        else              expTx = 1'b1;
        expBusy = 1'b1;
        expDone = (p == frameLen - 1);
      end else begin
        expTx   = 1'b1;
        expBusy = 1'b0;
        expDone = 1'b0;
      end
      obsTx   = useGap ? txG   : tx;
      obsBusy = useGap ? busyG : busy;
      obsDone = useGap ? doneG : done;
      if (obsTx !== expTx)     lineErr++;
      if (obsBusy !== expBusy) busyErr++;
      if (obsDone !== expDone) doneErr++;
      if (obsDone === 1'b1) begin
        doneCnt++;
        if (firstDone < 0) firstDone = k;
      end
      if (f == 0 && p < frameLen) cap[p] = obsTx;
      if (k == injectAt) begin
        start  = 1'b1;
        dataIn = injData;
      end
      if (injectAt >= 0 && k == injectAt + 1) start = 1'b0;
      if (holdStart && k == nFrames * (frameLen + 1) - 1) start = 1'b0;
      @(negedge clk);
    end
    checkOutput({tag, "_line_errs"}, lineErr, 0);
    checkOutput({tag, "_busy_errs"}, busyErr, 0);
    checkOutput({tag, "_done_errs"}, doneErr, 0);
    checkOutput({tag, "_done_count"}, doneCnt, nFrames);
    checkOutput({tag, "_first_done"}, firstDone, frameLen - 1);
    for (int bi = 0; bi < NB; bi++) begin
      for (int i = 0; i < 8; i++) dec[i] = cap[bi*per + (1+i)*CPB + CPB/2];
      checkOutput($sformatf("%s_byte%0d", tag, bi), dec, d[127 - 8*bi -: 8]);
    end
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    startG = 1'b0;
    dataIn = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_tx", tx, 1);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_tx_gap", txG, 1);
    checkOutput("rst_busy_gap", busyG, 0);
    checkOutput("rst_done_gap", doneG, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    applyStimulus(1'b0, 128'hABCDEF9876543210ABCDEF9876543210);
    observeFrames("t1", 1'b0, 128'hABCDEF9876543210ABCDEF9876543210, 1, 1'b0, -1, '0);

    applyStimulus(1'b0, 128'h0);
    observeFrames("t2_zero", 1'b0, 128'h0, 1, 1'b0, -1, '0);
    applyStimulus(1'b0, {128{1'b1}});
    observeFrames("t2_ones", 1'b0, {128{1'b1}}, 1, 1'b0, -1, '0);

    applyStimulus(1'b0, 128'h0123456789ABCDEF0F1E2D3C4B5A6978);
    observeFrames("t3", 1'b0, 128'h0123456789ABCDEF0F1E2D3C4B5A6978, 1, 1'b0, 100,
                  128'hDEADBEEFCAFEF00D1122334455667788);

    // All-zero word keeps the line low mid-frame, so the abort is visible on tx.
    applyStimulus(1'b0, 128'h0);
    repeat (300) @(negedge clk);
    checkOutput("t4_pre_tx", tx, 0);
    rst = 1'b1;
    #1;
    checkOutput("t4_abort_tx", tx, 1);
    checkOutput("t4_abort_busy", busy, 0);
    checkOutput("t4_abort_done", done, 0);
    repeat (3) @(negedge clk);
    rst    = 1'b0;
    start  = 1'b1;
    dataIn = 128'h5AA5C33C0FF0E11E96697887B44BD22D;
    @(negedge clk);
    checkOutput("t4_rel_ignore_busy", busy, 0);
    checkOutput("t4_rel_ignore_tx", tx, 1);
    applyStimulus(1'b0, 128'h5AA5C33C0FF0E11E96697887B44BD22D);
    observeFrames("t4", 1'b0, 128'h5AA5C33C0FF0E11E96697887B44BD22D, 1, 1'b0, -1, '0);

    // Start held high across three complete back-to-back frames.
    dataIn = 128'hC0FFEE00123456789ABCDEF011223344;
    start  = 1'b1;
    @(negedge clk);
    observeFrames("t5", 1'b0, 128'hC0FFEE00123456789ABCDEF011223344, 3, 1'b1, -1, '0);

    applyStimulus(1'b1, 128'h0123456789ABCDEFFEDCBA9876543210);
    observeFrames("t6_gap", 1'b1, 128'h0123456789ABCDEFFEDCBA9876543210, 1, 1'b0, -1, '0);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
